// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fill path, used by the responder and the cache.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } fill_state_t;

    localparam int WORD_W             = 32;
    localparam int IMEM_DEPTH_DEFAULT = 1024;

    // Word index of a byte address; callers truncate to their memory depth, which aliases upper bits.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/imem_bram.sv
// Synchronous instruction RAM: one read port and one write port, read-first on same-word collisions.
module imem_bram
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WORD_W-1:0]        o_rd_data,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WORD_W-1:0]        i_wr_data
);
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd_data;

    // Storage and read register; the read sees the pre-write contents of a colliding word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_fill_responder.sv
// Instruction-memory line-fill responder: streams LINE_WORDS consecutive words per fill request.
// Define IMEM_STREAM_PIPE_EN for the overlapped 1 word/cycle datapath with a 2-entry skid buffer.
module imem_fill_responder
    import imem_pkg::*;
#(
    parameter int LINE_WORDS = 12,
    parameter int MEM_DEPTH  = IMEM_DEPTH_DEFAULT,
    parameter int ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_pin,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WORD_W-1:0]             rsp_data,
    output logic [$clog2(LINE_WORDS)-1:0] rsp_idx,
    output logic                          rsp_last,
    output logic                          err,
    output logic                          busy,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WORD_W-1:0]             wr_data
);
    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    fill_state_t       r_state, w_state_n;
    logic [AW-1:0]     r_ptr, w_ptr_n;
    logic [AW-1:0]     w_req_ptr, w_wr_ptr, w_rd_addr;
    logic              w_rd_en, w_accept, w_misalign, w_err_n;
    logic [WORD_W-1:0] w_rd_data;
    logic              r_req_ready, r_busy, r_err;
    logic [IDX_W-1:0]  r_rsp_idx, w_idx_n;
    logic              r_rsp_last;

    assign w_req_ptr  = AW'(word_index(32'(req_addr)));
    assign w_wr_ptr   = AW'(word_index(32'(wr_addr)));
    assign w_misalign = |req_addr[1:0];
    assign w_accept   = req_valid & r_req_ready & (r_state == IDLE);

    imem_bram #(.DEPTH(MEM_DEPTH)) u_bram (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data),
        .i_wr_en   (wr_en),
        .i_wr_addr (w_wr_ptr),
        .i_wr_data (wr_data)
    );

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign err       = r_err;
    assign rsp_idx   = r_rsp_idx;
    assign rsp_last  = r_rsp_last;

`ifdef IMEM_STREAM_PIPE_EN
    localparam int CNT_W = $clog2(LINE_WORDS + 1);

    logic [CNT_W-1:0]  r_issued, w_issued_n;
    logic              r_q_valid;
    logic              r_o_valid, w_o_valid_n, r_s_valid, w_s_valid_n;
    logic [WORD_W-1:0] r_o_data, w_o_data_n, r_s_data, w_s_data_n;
    logic              w_last_n, w_pop, w_room;
    logic [1:0]        w_occ;

    // A read is only launched if its data is guaranteed a slot by the time it lands.
    assign w_pop  = r_o_valid & rsp_ready;
    assign w_occ  = {1'b0, r_o_valid} + {1'b0, r_s_valid} + {1'b0, r_q_valid};
    assign w_room = (w_occ - {1'b0, w_pop}) < 2'd2;

    // Next-state for the streaming read pipeline and its output/skid pair.
    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_issued_n  = r_issued;
        w_err_n     = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_addr   = r_ptr;
        w_o_valid_n = r_o_valid;
        w_o_data_n  = r_o_data;
        w_s_valid_n = r_s_valid;
        w_s_data_n  = r_s_data;
        w_idx_n     = r_rsp_idx;
        w_last_n    = r_rsp_last;
        case (r_state)
            IDLE: begin
                if (w_accept && w_misalign) begin
                    w_err_n = 1'b1;
                end else if (w_accept) begin
                    w_rd_en    = 1'b1;
                    w_rd_addr  = w_req_ptr;
                    w_ptr_n    = w_req_ptr + AW'(1);
                    w_issued_n = CNT_W'(1);
                    w_idx_n    = {IDX_W{1'b0}};
                    w_last_n   = 1'b0;
                    w_state_n  = SEND;
                end else begin
                    w_state_n = IDLE;
                end
            end
            SEND: begin
                if ((r_issued != CNT_W'(LINE_WORDS)) && w_room) begin
                    w_rd_en    = 1'b1;
                    w_ptr_n    = r_ptr + AW'(1);
                    w_issued_n = r_issued + CNT_W'(1);
                end else begin
                    w_rd_en = 1'b0;
                end
                if (w_pop) begin
                    w_idx_n  = r_rsp_idx + IDX_W'(1);
                    w_last_n = (r_rsp_idx + IDX_W'(1)) == LAST_IDX;
                    if (r_s_valid) begin
                        w_o_data_n  = r_s_data;
                        w_s_valid_n = 1'b0;
                    end else begin
                        w_o_valid_n = 1'b0;
                    end
                end else begin
                    w_idx_n = r_rsp_idx;
                end
                if (r_q_valid && !w_o_valid_n) begin
                    w_o_valid_n = 1'b1;
                    w_o_data_n  = w_rd_data;
                end else if (r_q_valid) begin
                    w_s_valid_n = 1'b1;
                    w_s_data_n  = w_rd_data;
                end else begin
                    w_s_valid_n = w_s_valid_n;
                end
                if (w_pop && r_rsp_last) begin
                    w_state_n   = IDLE;
                    w_idx_n     = {IDX_W{1'b0}};
                    w_last_n    = 1'b0;
                    w_o_valid_n = 1'b0;
                    w_s_valid_n = 1'b0;
                end else begin
                    w_state_n = SEND;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // Pipeline state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_pin) begin
            r_state     <= IDLE;
            r_ptr       <= {AW{1'b0}};
            r_issued    <= {CNT_W{1'b0}};
            r_q_valid   <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_data    <= {WORD_W{1'b0}};
            r_s_valid   <= 1'b0;
            r_s_data    <= {WORD_W{1'b0}};
            r_rsp_idx   <= {IDX_W{1'b0}};
            r_rsp_last  <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_issued    <= w_issued_n;
            r_q_valid   <= w_rd_en;
            r_o_valid   <= w_o_valid_n;
            r_o_data    <= w_o_data_n;
            r_s_valid   <= w_s_valid_n;
            r_s_data    <= w_s_data_n;
            r_rsp_idx   <= w_idx_n;
            r_rsp_last  <= w_last_n;
            r_req_ready <= (w_state_n == IDLE);
            r_busy      <= (w_state_n == SEND);
            r_err       <= w_err_n;
        end
    end

    assign rsp_valid = r_o_valid;
    assign rsp_data  = r_o_data;
`else
    logic [IDX_W-1:0] r_cnt;
    logic             r_rsp_valid;

    // Next-state for the fetch/send loop: one word every two cycles.
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_idx_n   = r_cnt;
        w_err_n   = 1'b0;
        w_rd_en   = 1'b0;
        w_rd_addr = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_accept && w_misalign) begin
                    w_err_n = 1'b1;
                end else if (w_accept) begin
                    w_ptr_n   = w_req_ptr;
                    w_idx_n   = {IDX_W{1'b0}};
                    w_state_n = FETCH;
                end else begin
                    w_state_n = IDLE;
                end
            end
            FETCH: begin
                w_rd_en   = 1'b1;
                w_state_n = SEND;
            end
            SEND: begin
                if (rsp_ready && (r_cnt == LAST_IDX)) begin
                    w_state_n = IDLE;
                end else if (rsp_ready) begin
                    w_ptr_n   = r_ptr + AW'(1);
                    w_idx_n   = r_cnt + IDX_W'(1);
                    w_state_n = FETCH;
                end else begin
                    w_state_n = SEND;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_pin) begin
            r_state     <= IDLE;
            r_ptr       <= {AW{1'b0}};
            r_cnt       <= {IDX_W{1'b0}};
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_idx   <= {IDX_W{1'b0}};
            r_rsp_last  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_cnt       <= w_idx_n;
            r_req_ready <= (w_state_n == IDLE);
            r_busy      <= (w_state_n != IDLE);
            r_err       <= w_err_n;
            r_rsp_valid <= (w_state_n == SEND);
            r_rsp_idx   <= w_idx_n;
            r_rsp_last  <= (w_state_n == SEND) && (w_idx_n == LAST_IDX);
        end
    end

    // The RAM read register holds its word while the cache stalls.
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_valid ? w_rd_data : {WORD_W{1'b0}};
`endif

endmodule

// File: tb/tb_imem_fill_responder.sv
// Randomized bench for imem_fill_responder, checked every cycle against a memory/queue model.
module tb_imem_fill_responder;
    localparam int LINE  = 12;
    localparam int DEPTH = 1024;
`ifdef IMEM_STREAM_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_pin, req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, err, busy, wr_en;
    logic [31:0] req_addr, rsp_data, wr_addr, wr_data;
    logic [3:0]  rsp_idx;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_fill_responder #(.LINE_WORDS(LINE), .MEM_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_pin(rst_pin), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_idx(rsp_idx), .rsp_last(rsp_last), .err(err), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: word memory, expected words of the fill in flight, and protocol flags.
    logic [31:0] mmem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] log_d [$];
    int          log_cyc [$];
    bit m_started = 0, m_after_rst = 0, m_active = 0, m_err_now = 0, m_first = 0, prev_hold = 0;
    int m_cnt = 0, m_since = 0, err_seen = 0, base = 0;

    always @(negedge clk) begin
        if (m_started && m_after_rst) begin
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_data", rsp_data, 32'd0);
            chk("rst_rsp_idx", {28'd0, rsp_idx}, 32'd0);
            chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end else if (m_started) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !m_active});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
            chk("err", {31'd0, err}, {31'd0, m_err_now});
            if (!m_active) chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
            else if (m_first && m_since < 2) chk("latency_early", {31'd0, rsp_valid}, 32'd0);
            else if (m_first && m_since == 2) chk("latency_first", {31'd0, rsp_valid}, 32'd1);
            if (prev_hold) chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            if (rsp_valid === 1'b1 && m_active && exp_q.size() > 0) begin
                chk("rsp_data", rsp_data, exp_q[0]);
                chk("rsp_idx", {28'd0, rsp_idx}, 32'(m_cnt));
                chk("rsp_last", {31'd0, rsp_last}, {31'd0, m_cnt == LINE - 1});
            end
            if (err === 1'b1) err_seen++;
        end
        // advance the model to the next cycle from the inputs now presented
        prev_hold = 0;
        if (rst_pin === 1'b0) begin
            m_started = 1; m_after_rst = 1; m_active = 0; m_err_now = 0;
            exp_q.delete();
        end else if (m_started) begin
            m_err_now = 0;
            if (m_active) begin
                m_since++;
                if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                    log_d.push_back(rsp_data);
                    log_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                    m_cnt++;
                    m_first = 0;
                    if (m_cnt == LINE) m_active = 0;
                end else if (rsp_valid === 1'b1) begin
                    prev_hold = 1;
                end
            end else if (req_valid && !m_after_rst) begin
                if (req_addr % 4 != 0) begin
                    m_err_now = 1;
                end else begin
                    base = int'((req_addr / 4) % DEPTH);
                    for (int i = 0; i < LINE; i++) exp_q.push_back(mmem[(base + i) % DEPTH]);
                    m_active = 1; m_first = 1; m_cnt = 0; m_since = 1;
                end
            end
            m_after_rst = 0;
            if (wr_en) mmem[(wr_addr / 4) % DEPTH] = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_pin = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
        repeat (n) tick();
        rst_pin = 1'b1;
        tick();
    endtask

    task automatic write_word(input int w, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = (32'(w) << 2) | ($urandom & 32'hFFFF_F003) & 32'hFFFF_0003;
        wr_addr = wr_addr | (32'(w) << 2);
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_fill(input logic [31:0] a, input int mode);
        bit done = 0;
        int t = 0;
        log_d.delete(); log_cyc.delete(); err_seen = 0;
        req_valid = 1'b1; req_addr = a;
        rsp_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        while (!done && t < 50) begin
            @(negedge clk);
            if (req_ready === 1'b1) done = 1;
            t++;
        end
        chk("accept_timeout", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic finish_fill(input int mode);
        int t = 0;
        while (log_d.size() < LINE && t < 400) begin
            tick();
            wr_en = 1'b0;
            rsp_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            t++;
        end
        chk("fill_words", 32'(log_d.size()), 32'(LINE));
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [31:0] old_w, ra;
    int t;

    initial begin
        rst_pin = 1'b0; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0;
        wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
        do_reset(3);
        // preload: random everywhere, then known words used by the literal checks
        for (int w = 0; w < DEPTH; w++) write_word(w, $urandom);
        for (int w = 0; w < 16; w++) write_word(w, 32'h0000_0013 + 32'(w));
        write_word(1022, 32'hCAFE_03FE);
        write_word(1023, 32'hCAFE_03FF);
        tick();

        start_fill(32'h0000_0000, 0);
        finish_fill(0);
        if (log_d.size() == LINE) begin
            chk("line0_w0", log_d[0], 32'h0000_0013);
            chk("line0_w5", log_d[5], 32'h0000_0018);
            chk("line0_w11", log_d[11], 32'h0000_001E);
`ifdef IMEM_STREAM_PIPE_EN
            chk("pipe_back_to_back", 32'(log_cyc[11] - log_cyc[0]), 32'd11);
`endif
        end

        start_fill(32'h0000_0FF8, 0);
        finish_fill(0);
        if (log_d.size() == LINE) begin
            chk("wrap_w0", log_d[0], 32'hCAFE_03FE);
            chk("wrap_w1", log_d[1], 32'hCAFE_03FF);
            chk("wrap_w2", log_d[2], 32'h0000_0013);
            chk("wrap_w11", log_d[11], 32'h0000_001C);
        end

        start_fill(32'h0000_0006, 0);
        tick(); tick(); tick();
        chk("misalign_err_pulses", 32'(err_seen), 32'd1);
        chk("misalign_no_words", 32'(log_d.size()), 32'd0);

        start_fill(32'h0000_0040, 1);
        finish_fill(1);

        // reset after the fifth word aborts the burst
        start_fill(32'h0000_0000, 0);
        t = 0;
        while (log_d.size() < 5 && t < 100) begin tick(); t++; end
        rst_pin = 1'b0; rsp_ready = 1'b0;
        tick();
        rst_pin = 1'b1;
        tick(); tick();
        chk("abort_words", 32'(log_d.size()), 32'd5);
        start_fill(32'h0000_0000, 0);
        finish_fill(0);
        if (log_d.size() == LINE) begin
            chk("clean_w0", log_d[0], 32'h0000_0013);
            chk("clean_w11", log_d[11], 32'h0000_001E);
        end

        // write colliding with the read of a word in the same cycle returns the old word
        old_w = mmem[100 + PIPE];
        start_fill(32'd400, 0);
        wr_en = 1'b1; wr_addr = 32'(100 + PIPE) * 32'd4; wr_data = 32'hDEAD_BEEF;
        finish_fill(0);
        if (log_d.size() == LINE) chk("read_first_old", log_d[PIPE], old_w);
        start_fill(32'd400, 0);
        finish_fill(0);
        if (log_d.size() == LINE) chk("read_first_new", log_d[PIPE], 32'hDEAD_BEEF);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 1) == 1) write_word($urandom_range(0, DEPTH - 1), $urandom);
            ra = $urandom;
            if ($urandom_range(0, 5) != 0) ra[1:0] = 2'b00;
            if (ra[1:0] != 2'b00) begin
                start_fill(ra, 0);
                tick(); tick();
                chk("rand_err_pulses", 32'(err_seen), 32'd1);
            end else begin
                start_fill(ra, n % 2);
                finish_fill(n % 2);
            end
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
